// File: rtl/if_id_queue.sv
// Instruction fetch queue: small circular FIFO of {pc, inst} between fetch and decode.
// Optional same-cycle fetch-to-decode bypass when empty is enabled with `define IFQ_BYPASS_EN.
module if_id_queue #(
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_valid,
    input  logic [95:0]                i_if_id_regs,
    output logic                       o_stall,
    output logic                       o_valid,
    output logic [95:0]                o_if_id_regs,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [95:0]   NOP_ENTRY  = {64'h0, 32'h0000_0013};

    logic [95:0]   mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic notEmpty;
    logic bypass;
    logic push;
    logic pop;

    assign full     = (count_q == FULL_COUNT);
    assign notEmpty = (count_q != '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = ~notEmpty & i_valid & ~i_flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry consumed in the same cycle never touches storage.
    assign push = i_valid & ~full & ~i_flush & ~(bypass & i_ready);
    assign pop  = notEmpty & ~i_flush & i_ready;

    assign o_stall = full;
    assign o_valid = (notEmpty | bypass) & ~i_flush;
    assign o_count = count_q;

    always_comb begin
        o_if_id_regs = NOP_ENTRY;
        if (notEmpty && !i_flush) begin
            o_if_id_regs = mem_q[rdPtr_q];
        end else if (bypass) begin
            o_if_id_regs = i_if_id_regs;
        end
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (i_flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; the output mux never exposes an unwritten slot.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= i_if_id_regs;
        end
    end

    countInRange: assert property (@(posedge i_clk) disable iff (!i_rst_n) count_q <= FULL_COUNT);

endmodule

// File: tb/tb_if_id_queue.sv
// Directed testbench for if_id_queue with DEPTH = 2.
// Expectations follow the default build and the IFQ_BYPASS_EN build alike.
module tb_if_id_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic [95:0] inRegs;
    logic        stall;
    logic        outValid;
    logic [95:0] outRegs;
    logic        ready;
    logic [1:0]  count;

    int testsRun;
    int testsFailed;

    localparam logic [95:0] NOP_ENTRY = {64'h0, 32'h0000_0013};

    if_id_queue #(.DEPTH(2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_valid      (valid),
        .i_if_id_regs (inRegs),
        .o_stall      (stall),
        .o_valid      (outValid),
        .o_if_id_regs (outRegs),
        .i_ready      (ready),
        .o_count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [95:0] entry(input logic [63:0] pc);
        return {pc, 32'h1000_0000 | pc[31:0]};
    endfunction

    task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic r, input logic f);
        valid  = v;
        inRegs = entry(pc);
        ready  = r;
        flush  = f;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic v, input logic s, input logic [1:0] c);
        checkOutput({tag, "_valid"}, 96'(outValid), 96'(v));
        checkOutput({tag, "_stall"}, 96'(stall), 96'(s));
        checkOutput({tag, "_count"}, 96'(count), 96'(c));
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n  = 1'b0;
        valid  = 1'b0;
        ready  = 1'b0;
        flush  = 1'b0;
        inRegs = '0;

        // Reset state
        #12;
        checkState("reset", 1'b0, 1'b0, 2'd0);
        checkOutput("reset_regs", outRegs, NOP_ENTRY);
        @(negedge clk);
        rst_n = 1'b1;
        stepClock();

        // Fill to full, third push ignored
        applyStimulus(1'b1, 64'h0, 1'b0, 1'b0);
        stepClock();
        checkState("fill1", 1'b1, 1'b0, 2'd1);
        checkOutput("fill1_head", outRegs, entry(64'h0));
        applyStimulus(1'b1, 64'h4, 1'b0, 1'b0);
        stepClock();
        checkState("fill2", 1'b1, 1'b1, 2'd2);
        applyStimulus(1'b1, 64'h8, 1'b0, 1'b0);
        stepClock();
        checkState("fill3", 1'b1, 1'b1, 2'd2);
        checkOutput("fill3_head", outRegs, entry(64'h0));

        // Drain in order
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        checkOutput("drain_head0", outRegs, entry(64'h0));
        stepClock();
        checkState("drain1", 1'b1, 1'b0, 2'd1);
        checkOutput("drain_head1", outRegs, entry(64'h4));
        stepClock();
        checkState("drain2", 1'b0, 1'b0, 2'd0);
        checkOutput("drain_regs", outRegs, NOP_ENTRY);

        // Simultaneous push/pop with pointer wrap
        applyStimulus(1'b1, 64'hC, 1'b0, 1'b0);
        stepClock();
        checkState("pp_pre", 1'b1, 1'b0, 2'd1);
        checkOutput("pp_headC", outRegs, entry(64'hC));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 64'h10 + 64'(4 * i), 1'b1, 1'b0);
            stepClock();
            checkOutput("pp_count", 96'(count), 96'd1);
            checkOutput("pp_head", outRegs, entry(64'h10 + 64'(4 * i)));
        end
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        stepClock();
        checkState("pp_empty", 1'b0, 1'b0, 2'd0);

        // Flush with a same-cycle push and pop
        applyStimulus(1'b1, 64'h100, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b1, 64'h104, 1'b0, 1'b0);
        stepClock();
        checkState("fl_full", 1'b1, 1'b1, 2'd2);
        applyStimulus(1'b1, 64'h20, 1'b1, 1'b1);
        checkOutput("fl_valid", 96'(outValid), 96'd0);
        checkOutput("fl_regs", outRegs, NOP_ENTRY);
        stepClock();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        checkState("fl_after", 1'b0, 1'b0, 2'd0);
        checkOutput("fl_regs_after", outRegs, NOP_ENTRY);

        // Bypass path from empty
        valid  = 1'b1;
        inRegs = {64'h40, 32'h0050_0093};
        ready  = 1'b1;
        flush  = 1'b0;
        #1;
`ifdef IFQ_BYPASS_EN
        checkState("bp_same", 1'b1, 1'b0, 2'd0);
        checkOutput("bp_same_regs", outRegs, {64'h40, 32'h0050_0093});
        stepClock();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        checkState("bp_next", 1'b0, 1'b0, 2'd0);
`else
        checkState("bp_same", 1'b0, 1'b0, 2'd0);
        checkOutput("bp_same_regs", outRegs, NOP_ENTRY);
        stepClock();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        checkState("bp_next", 1'b1, 1'b0, 2'd1);
        checkOutput("bp_next_regs", outRegs, {64'h40, 32'h0050_0093});
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        stepClock();
        checkState("bp_drain", 1'b0, 1'b0, 2'd0);
`endif

        // Asynchronous reset mid-stream while full
        applyStimulus(1'b1, 64'h200, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b1, 64'h204, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        checkState("rs_full", 1'b1, 1'b1, 2'd2);
        rst_n = 1'b0;
        #1;
        checkState("rs_async", 1'b0, 1'b0, 2'd0);
        checkOutput("rs_regs", outRegs, NOP_ENTRY);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
